ensemble_vote_collector: RTL

- Receiving end of the three classifier result streams: Gaussian NB on lane 1, logistic regression on lane 2, MLP on lane 3.
- Holds one result word per lane and joins the three lanes. Once all three are present, it computes a 2-of-3 majority vote and emits one combined result word on a single AXI-Stream master.
- Keeps a sticky framing-error flag and result/disagreement counters for the host.

---
 rtl/ensemble_vote_collector_if.sv | 20 ++
 rtl/ensemble_vote_collector.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ensemble_vote_collector_if.sv
// AXI-Stream link used by the vote collector: one instance per classifier lane
// and one for the combined result stream.
//   tdata  : payload word
//   tkeep  : byte qualifiers
//   tvalid : source has a word
//   tready : sink can take the word
//   tlast  : end-of-batch marker
interface ensemble_vote_collector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/ensemble_vote_collector.sv
// Joins the three classifier result lanes (1: Gaussian NB, 2: logistic
// regression, 3: MLP), takes a 2-of-3 majority vote on the class labels and
// emits one combined word per triple.
//   clk, rst_n         : clock, asynchronous active-low reset
//   s_axis_1/2/3       : lane inputs; label in tdata[CLASS_WIDTH-1:0]
//   m_axis             : result word {mismatch[31], count[17:16], class}
//   tlast_mismatch     : sticky, set when a triple arrives with unequal tlasts
//   result_count       : results issued (wraps)
//   disagree_count     : results whose vote was not unanimous (wraps)
module ensemble_vote_collector #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = 8,
  parameter int TIE_LANE    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ensemble_vote_collector_if.slave     s_axis_1,
  ensemble_vote_collector_if.slave     s_axis_2,
  ensemble_vote_collector_if.slave     s_axis_3,
  ensemble_vote_collector_if.master    m_axis,
  output logic                         tlast_mismatch,
  output logic [31:0]                  result_count,
  output logic [31:0]                  disagree_count
);

  localparam int TIE_IDX = TIE_LANE - 1;

  logic [2:0]             full;
  logic [2:0]             last;
  logic [CLASS_WIDTH-1:0] label [3];
  logic                   ready_en;

  logic [2:0]             tvalid_in;
  logic [2:0]             last_in;
  logic [CLASS_WIDTH-1:0] label_in [3];
  logic [2:0]             capture;
  logic                   fire;

  logic                   m_valid;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_last;

  logic                   eq12, eq13, eq23;
  logic [CLASS_WIDTH-1:0] vote_class;
  logic [1:0]             vote_count;
  logic                   frame_err;
  logic [DATA_WIDTH-1:0]  vote_word;
  logic                   unused_bits;

  assign tvalid_in   = {s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid};
  assign last_in     = {s_axis_3.tlast, s_axis_2.tlast, s_axis_1.tlast};
  assign label_in[0] = s_axis_1.tdata[CLASS_WIDTH-1:0];
  assign label_in[1] = s_axis_2.tdata[CLASS_WIDTH-1:0];
  assign label_in[2] = s_axis_3.tdata[CLASS_WIDTH-1:0];

  assign unused_bits = ^{s_axis_1.tkeep, s_axis_2.tkeep, s_axis_3.tkeep,
                         s_axis_1.tdata[DATA_WIDTH-1:CLASS_WIDTH],
                         s_axis_2.tdata[DATA_WIDTH-1:CLASS_WIDTH],
                         s_axis_3.tdata[DATA_WIDTH-1:CLASS_WIDTH]};

  // ready_en holds tready low until the first clock after reset release,
  // so no lane is accepted while reset is still settling.
  assign s_axis_1.tready = ready_en & ~full[0];
  assign s_axis_2.tready = ready_en & ~full[1];
  assign s_axis_3.tready = ready_en & ~full[2];

  assign capture = tvalid_in & ~full & {3{ready_en}};
  assign fire    = (&full) & (~m_valid | m_axis.tready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      full     <= '0;
      last     <= '0;
      for (int i = 0; i < 3; i++) label[i] <= '0;
    end else begin
      ready_en <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        // capture and fire are exclusive per lane: fire needs full[i]
        if (capture[i]) begin
          full[i]  <= 1'b1;
          label[i] <= label_in[i];
          last[i]  <= last_in[i];
        end else if (fire) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    eq12       = (label[0] == label[1]);
    eq13       = (label[0] == label[2]);
    eq23       = (label[1] == label[2]);
    vote_class = label[TIE_IDX];
    vote_count = 2'd1;
    if (eq12 || eq13) begin
      vote_class = label[0];
      vote_count = 2'd1 + {1'b0, eq12} + {1'b0, eq13};
    end else if (eq23) begin
      vote_class = label[1];
      vote_count = 2'd2;
    end
    frame_err                      = !((last == 3'b000) || (last == 3'b111));
    vote_word                      = '0;
    vote_word[CLASS_WIDTH-1:0]     = vote_class;
    vote_word[17:16]               = vote_count;
    vote_word[31]                  = frame_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid        <= 1'b0;
      m_data         <= '0;
      m_last         <= 1'b0;
      tlast_mismatch <= 1'b0;
      result_count   <= '0;
      disagree_count <= '0;
    end else if (fire) begin
      // a fire during an output handshake replaces the word with no bubble
      m_valid      <= 1'b1;
      m_data       <= vote_word;
      m_last       <= |last;
      result_count <= result_count + 32'd1;
      if (vote_count != 2'd3) disagree_count <= disagree_count + 32'd1;
      if (frame_err) tlast_mismatch <= 1'b1;
    end else if (m_valid && m_axis.tready) begin
      m_valid <= 1'b0;
    end
  end

  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = m_data;
  assign m_axis.tlast  = m_last;
  assign m_axis.tkeep  = {KEEP_WIDTH{m_valid}};

endmodule
